// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the multi-channel serial adder.
// Optional feature macro used across this slice: SERIAL_ADDER_ACC_EN.
package serial_adder_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic {
    MODE_ADD,
    MODE_SUB
  } mode_e;

  // Two's-complement overflow: the carry into the MSB disagrees with the carry out of it.
  function automatic logic signedOverflow(input logic msbCarryIn, input logic msbCarryOut);
    return msbCarryIn ^ msbCarryOut;
  endfunction

endpackage

// File: rtl/serial_adder_lane.sv
// serial_adder_lane: one lane's bit-serial datapath (carry, registered sum, end-of-word flags).
// With SERIAL_ADDER_ACC_EN defined, the lane also keeps its previous completed result
// and can use it as operand B instead of in2_i.
module serial_adder_lane
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bitValid_i,
  input  logic                       first_i,
  input  logic                       last_i,
  input  logic                       abort_i,
  input  logic                       sub_i,
  input  logic                       in1_i,
  input  logic                       in2_i,
`ifdef SERIAL_ADDER_ACC_EN
  input  logic                       accSel_i,
  input  logic [$clog2(WIDTH)-1:0]   bitIdx_i,
`endif
  output logic                       sum_o,
  output logic                       cout_o,
  output logic                       ovf_o
);

  logic carry_q, carry_d;
  logic sum_q, cout_q, ovf_q;
  logic carryIn, opB, sumBit, carryOut;

`ifdef SERIAL_ADDER_ACC_EN
  // accQ holds the last completed word; resQ collects the word in flight LSB-first
  // so an aborted word never disturbs accQ.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rawB;
  assign rawB = accSel_i ? acc_q[bitIdx_i] : in2_i;
`else
  logic rawB;
  assign rawB = in2_i;
`endif

  // Full-adder slice: bit 0 takes the mode as carry-in, B is inverted when subtracting.
  always_comb begin
    carryIn  = first_i ? sub_i : carry_q;
    opB      = rawB ^ sub_i;
    sumBit   = in1_i ^ opB ^ carryIn;
    carryOut = (in1_i & opB) | (in1_i & carryIn) | (opB & carryIn);
  end

  // Next carry: cleared on abort and at word end so no stale carry survives a word boundary.
  always_comb begin
    carry_d = carry_q;
    if (abort_i) begin
      carry_d = 1'b0;
    end else if (bitValid_i) begin
      carry_d = last_i ? 1'b0 : carryOut;
    end
  end

`ifdef SERIAL_ADDER_ACC_EN
  // Result collection and commit of the finished word into the accumulator.
  always_comb begin
    res_d = res_q;
    acc_d = acc_q;
    if (bitValid_i) begin
      res_d = {sumBit, res_q[WIDTH-1:1]};
      if (last_i) begin
        acc_d = {sumBit, res_q[WIDTH-1:1]};
      end
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      acc_q <= '0;
    end else begin
      res_q <= res_d;
      acc_q <= acc_d;
    end
  end
`endif

  // Registered lane outputs: data only while valid, flags only on the word's last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      sum_q   <= bitValid_i & sumBit;
      cout_q  <= bitValid_i & last_i & carryOut;
      ovf_q   <= bitValid_i & last_i & signedOverflow(carryIn, carryOut);
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/serial_adder_mc.sv
// serial_adder_mc: CH-lane bit-serial adder/subtractor with shared framing, counter and mode.
// Optional feature macro: SERIAL_ADDER_ACC_EN (adds acc_i and a per-lane accumulator).
module serial_adder_mc
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          sub_i,
`ifdef SERIAL_ADDER_ACC_EN
  input  logic          acc_i,
`endif
  input  logic [CH-1:0] in1,
  input  logic [CH-1:0] in2,
  output logic          en_o,
  output logic [CH-1:0] out,
  output logic          last_o,
  output logic [CH-1:0] cout_o,
  output logic [CH-1:0] ovf_o,
  output logic          err_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         mode_q, mode_d, modeEff;
  logic          first, last, bitValid, abort;
  logic          en_q, last_q, err_q;

`ifdef SERIAL_ADDER_ACC_EN
  logic acc_q, acc_d, accEff;
`endif

  // Framing FSM: IDLE accepts bit 0 and samples the mode; RUN counts bits or aborts on a gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    modeEff  = mode_q;
    first    = 1'b0;
    last     = 1'b0;
    bitValid = 1'b0;
    abort    = 1'b0;
`ifdef SERIAL_ADDER_ACC_EN
    acc_d    = acc_q;
    accEff   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (en_i) begin
          first    = 1'b1;
          bitValid = 1'b1;
          modeEff  = sub_i ? MODE_SUB : MODE_ADD;
          mode_d   = modeEff;
`ifdef SERIAL_ADDER_ACC_EN
          accEff   = acc_i;
          acc_d    = acc_i;
`endif
          cnt_d    = CW'(1);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (en_i) begin
          bitValid = 1'b1;
          if (cnt_q == LAST_IDX) begin
            last    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered framing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_ADD;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      en_q    <= bitValid;
      last_q  <= last;
      err_q   <= abort;
    end
  end

`ifdef SERIAL_ADDER_ACC_EN
  // Accumulate-mode latch, held for the whole word like the add/sub mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  for (genvar g = 0; g < CH; g++) begin : gLane
    serial_adder_lane #(
      .WIDTH(WIDTH)
    ) uLane (
      .clk       (clk),
      .rst_n     (rst_n),
      .bitValid_i(bitValid),
      .first_i   (first),
      .last_i    (last),
      .abort_i   (abort),
      .sub_i     (modeEff == MODE_SUB),
      .in1_i     (in1[g]),
      .in2_i     (in2[g]),
`ifdef SERIAL_ADDER_ACC_EN
      .accSel_i  (accEff),
      .bitIdx_i  (cnt_q),
`endif
      .sum_o     (out[g]),
      .cout_o    (cout_o[g]),
      .ovf_o     (ovf_o[g])
    );
  end

  assign en_o   = en_q;
  assign last_o = last_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_serial_adder_mc.sv
// tb_serial_adder_mc: directed vectors with a scoreboard queue and an independent monitor.
// Build with SERIAL_ADDER_ACC_EN defined to also exercise the accumulator path.
module tb_serial_adder_mc;

  localparam int WIDTH = 8;
  localparam int CH    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enIn = 1'b0;
  logic       subIn = 1'b0;
  logic [1:0] in1Bits = '0;
  logic [1:0] in2Bits = '0;
`ifdef SERIAL_ADDER_ACC_EN
  logic       accIn = 1'b0;
`endif
  logic       enOut, lastOut, errOut;
  logic [1:0] outBits, coutBits, ovfBits;

  int compared = 0;
  int mismatched = 0;
  int cycleCnt = 0;

  typedef struct {
    bit         isErr;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [1:0] c;
    logic [1:0] v;
    int         cyc;
  } expT;

  expT sbQ[$];

  serial_adder_mc #(
    .WIDTH(WIDTH),
    .CH   (CH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (enIn),
    .sub_i (subIn),
`ifdef SERIAL_ADDER_ACC_EN
    .acc_i (accIn),
`endif
    .in1   (in1Bits),
    .in2   (in2Bits),
    .en_o  (enOut),
    .out   (outBits),
    .last_o(lastOut),
    .cout_o(coutBits),
    .ovf_o (ovfBits),
    .err_o (errOut)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle stamp used to check output latency.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full word on both lanes; mode inputs are inverted after bit 0 to prove they are latched.
  task automatic applyStimulus(input logic sub, input logic acc,
                               input logic [7:0] a0, input logic [7:0] b0,
                               input logic [7:0] a1, input logic [7:0] b1,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [1:0] c, input logic [1:0] v);
    expT e;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      enIn    = 1'b1;
      subIn   = (i == 0) ? sub : ~sub;
`ifdef SERIAL_ADDER_ACC_EN
      accIn   = (i == 0) ? acc : ~acc;
`endif
      in1Bits = {a1[i], a0[i]};
      in2Bits = {b1[i], b0[i]};
      if (i == WIDTH - 1) begin
        e.isErr = 1'b0;
        e.w0    = e0;
        e.w1    = e1;
        e.c     = c;
        e.v     = v;
        e.cyc   = cycleCnt + 1;
        sbQ.push_back(e);
      end
    end
    if (acc) begin
      // acc only matters when the accumulator build is in use
    end
  endtask

  task automatic applyPartial(input int n, input logic [7:0] a0, input logic [7:0] b0,
                              input logic [7:0] a1, input logic [7:0] b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enIn    = 1'b1;
      subIn   = 1'b0;
      in1Bits = {a1[i], a0[i]};
      in2Bits = {b1[i], b0[i]};
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enIn    = 1'b0;
      subIn   = 1'b0;
      in1Bits = '0;
      in2Bits = '0;
`ifdef SERIAL_ADDER_ACC_EN
      accIn   = 1'b0;
`endif
    end
  endtask

  int         nBits = 0;
  logic [7:0] cap0 = '0;
  logic [7:0] cap1 = '0;
  expT        mon;

  // Monitor: collect output bits and pop the scoreboard on every last_o or err_o.
  always @(negedge clk) begin
    if (!rst_n) begin
      nBits = 0;
    end else begin
      if (!enOut) checkOutput("outZeroWhenIdle", 32'(outBits), 32'd0);
      if (!lastOut) checkOutput("flagsZeroOffLast", 32'({coutBits, ovfBits}), 32'd0);
      if (enOut && nBits < WIDTH) begin
        cap0[nBits] = outBits[0];
        cap1[nBits] = outBits[1];
      end
      if (enOut) nBits++;
      if (lastOut || errOut) begin
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedEvent: got last=%0b err=%0b, expected no event", lastOut, errOut);
        end else begin
          mon = sbQ.pop_front();
          checkOutput("eventKind", 32'({lastOut, errOut}), mon.isErr ? 32'd1 : 32'd2);
          checkOutput("eventCycle", 32'(cycleCnt), 32'(mon.cyc));
          if (mon.isErr) begin
            checkOutput("enOutOnErr", 32'(enOut), 32'd0);
          end else begin
            checkOutput("bitCount", 32'(nBits), 32'(WIDTH));
            checkOutput("lane0Word", 32'(cap0), 32'(mon.w0));
            checkOutput("lane1Word", 32'(cap1), 32'(mon.w1));
            checkOutput("cout", 32'(coutBits), 32'(mon.c));
            checkOutput("ovf", 32'(ovfBits), 32'(mon.v));
          end
        end
        nBits = 0;
      end
    end
  end

  // Directed sequence; every expected value below is hand-computed.
  initial begin
    expT errExp;
    #1;
    checkOutput("resetState", 32'({enOut, outBits, lastOut, coutBits, ovfBits, errOut}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    // add: 0x35+0x4A, 0x10+0x20
    applyStimulus(1'b0, 1'b0, 8'h35, 8'h4A, 8'h10, 8'h20, 8'h7F, 8'h30, 2'b00, 2'b00);
    idleCycles(2);
    // add: 0xFF+0x01 carries out, 0x7F+0x01 overflows
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'h01, 8'h7F, 8'h01, 8'h00, 8'h80, 2'b01, 2'b10);
    idleCycles(1);
    // sub: 0x80-0x01 overflows with no borrow, 0x00-0x01 borrows
    applyStimulus(1'b1, 1'b0, 8'h80, 8'h01, 8'h00, 8'h01, 8'h7F, 8'hFF, 2'b01, 2'b01);
    idleCycles(1);
    // back-to-back: add then sub with no gap
    applyStimulus(1'b0, 1'b0, 8'h12, 8'h34, 8'hF0, 8'h20, 8'h46, 8'h10, 2'b10, 2'b00);
    applyStimulus(1'b1, 1'b0, 8'h50, 8'h30, 8'h30, 8'h50, 8'h20, 8'hE0, 2'b01, 2'b00);
    idleCycles(2);
    // sub: 0x7F-0x80 overflows, 0x05-0x03 no borrow
    applyStimulus(1'b1, 1'b0, 8'h7F, 8'h80, 8'h05, 8'h03, 8'hFF, 8'h02, 2'b10, 2'b01);
    idleCycles(1);

    // abort after 3 bits, then a clean 0x01+0x01
    applyPartial(3, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clk);
    enIn = 1'b0;
    errExp.isErr = 1'b1;
    errExp.w0    = '0;
    errExp.w1    = '0;
    errExp.c     = '0;
    errExp.v     = '0;
    errExp.cyc   = cycleCnt + 1;
    sbQ.push_back(errExp);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 2'b00, 2'b00);
    idleCycles(2);

    // reset asserted while bit 4 is presented
    applyPartial(5, 8'h35, 8'h4A, 8'h10, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetClears", 32'({enOut, outBits, lastOut, coutBits, ovfBits, errOut}), 32'd0);
    idleCycles(1);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 8'h35, 8'h4A, 8'h10, 8'h20, 8'h7F, 8'h30, 2'b00, 2'b00);
    idleCycles(2);

`ifdef SERIAL_ADDER_ACC_EN
    // accumulate: 0x05 (+0) then 0x03 + previous 0x05; lane 1 0x10 then 0x01 + 0x10
    applyStimulus(1'b0, 1'b0, 8'h05, 8'h00, 8'h10, 8'h00, 8'h05, 8'h10, 2'b00, 2'b00);
    idleCycles(1);
    applyStimulus(1'b0, 1'b1, 8'h03, 8'hAA, 8'h01, 8'h55, 8'h08, 8'h11, 2'b00, 2'b00);
    idleCycles(2);
`endif

    for (int i = 0; i < 50 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);
    idleCycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_adder_mc.md
Name: serial_adder_mc

Overview:
Multi-channel, parametrised bit-serial adder/subtractor. It is the successor to the single-bit 1-lane serial adder.
- Operands arrive LSB-first, framed by en_i as WIDTH-bit words, on CH independent lanes that share one framing/control path.
- Results stream out LSB-first with 1-cycle latency, framed by en_o.
- Per-word end-of-word flags: carry-out, signed overflow, abort error.
- Sits between the serial operand sources and the serial result consumer in the datapath.

Parameters:
WIDTH, 8, bits per word (>=2)
CH, 1, number of independent lanes (>=1)

Ports:
clk      in   1    clock, all logic on posedge
rst_n    in   1    asynchronous active-low reset
en_i     in   1    input frame valid; one operand bit per lane per cycle
sub_i    in   1    mode, sampled on bit 0 of each word: 0 = in1+in2, 1 = in1-in2
in1      in   CH   operand A bit, one per lane
in2      in   CH   operand B bit, one per lane
en_o     out  1    output bit valid
out      out  CH   result bit, one per lane
last_o   out  1    qualifies the output bit of index WIDTH-1
cout_o   out  CH   carry-out of the word, valid only when last_o=1, else 0
ovf_o    out  CH   signed overflow, valid only when last_o=1, else 0
err_o    out  1    one-cycle pulse: word aborted

Behaviour:
- Reset (rst_n=0, asynchronous): en_o, out, last_o, cout_o, ovf_o, err_o all 0; state IDLE; bit counter 0; carries 0.
- Control FSM has two states, IDLE and RUN; bit counter cnt is $clog2(WIDTH) bits.
- IDLE, en_i=1: bit 0 of a word.
  - Latch sub_i into mode_q.
  - Effective carry-in = sub_i.
  - Operand B = in2 ^ sub_i.
  - cnt <= 1; go to RUN.
  - If WIDTH bits are consumed the same cycle (not possible, WIDTH>=2), ignore.
- RUN, en_i=1: per lane, sum = in1 ^ Beff ^ c and c <= majority(in1, Beff, c).
  - cnt increments.
  - At cnt=WIDTH-1 the word completes and cnt <= 0.
  - If en_i is still 1 the next cycle, that cycle is bit 0 of the next word. Back-to-back words have no gap; mode is resampled each word.
  - Otherwise return to IDLE.
- RUN, en_i=0 with cnt!=0: abort.
  - err_o=1 on the next cycle; en_o=0 that cycle.
  - cnt <= 0, carries cleared, state IDLE.
  - No last_o, cout_o or ovf_o is produced for the aborted word.
- Output timing: all outputs registered.
  - out/en_o reflect the input bit of the previous cycle.
  - last_o=1 coincides with the output bit WIDTH-1.
- Flags at word end:
  - cout_o = final carry. For subtract this is 1 when there is no borrow.
  - ovf_o = carry into MSB XOR carry out of MSB.
- When en_o=0, out is 0.
- Lanes are fully independent in data; they share cnt, mode_q, en/last/err.
- Reset mid-word: outputs clear immediately; the partial word is discarded; the first en_i=1 after reset release is bit 0.

Optional Feature:
Macro: SERIAL_ADDER_ACC_EN
- Defined: adds input port acc_i (1 bit), sampled on bit 0 like sub_i.
  - When acc_i=1, in2 is ignored. Operand B for each lane is the previous completed result of that lane, held in a per-lane WIDTH-bit shift register that rotates LSB-first in lockstep with the word.
  - Every completed word (acc_i 0 or 1) loads its result into the register. Aborted words do not update it.
  - The register is cleared by reset.
- Undefined: no acc_i port and no shift register; in2 is always operand B.

Decomposition:
- Package serial_adder_pkg holds:
  - state_e (IDLE, RUN)
  - mode_e (MODE_ADD, MODE_SUB)
  - a function for signed-overflow detection
- Sub-module serial_adder_lane holds one lane's datapath: carry reg, sum reg, MSB carry-in capture, and the optional accumulator register. It is instantiated CH times in a generate loop.
- FSM and counter live in the top level.

Test Plan:
- WIDTH=8, CH=2, add: ch0 0x35+0x4A, ch1 0x10+0x20 -> out words 0x7F / 0x30, cout=0/0, ovf=0/0, last_o on 8th en_o cycle, latency 1.
- Add 0xFF+0x01 (ch0), 0x7F+0x01 (ch1) -> 0x00 with cout=1, ovf=0; 0x80 with cout=0, ovf=1.
- Subtract 0x80-0x01 -> 0x7F, cout=1, ovf=1; subtract 0x00-0x01 -> 0xFF, cout=0, ovf=0.
- Two words back-to-back, add then sub, no gap -> both results correct; exactly two last_o pulses, 8 cycles apart.
- en_i dropped after 3 bits -> err_o pulse 1 cycle, no last_o; a following 0x01+0x01 gives 0x02.
- rst_n asserted at bit 4 -> all outputs 0 asynchronously; after release 0x35+0x4A gives 0x7F.
- With SERIAL_ADDER_ACC_EN: word 0x05 (acc_i=0, in2=0), then 0x03 with acc_i=1 -> second result 0x08.
